// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared constants and types for the Booth multiplier
//
// Purpose: default operand width, step-counter width and FSM state type
// used by booth_multiplier and booth_step.
// Ports: none (package).
package booth_pkg;

  localparam int BOOTH_WIDTH = 8;
  localparam int BOOTH_CNT_W = $clog2(BOOTH_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } booth_state_e;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth recode/add/shift step
//
// Purpose: given the current {acc, q, q_m1} and the multiplicand m, apply the
// Booth add/subtract selected by {q[0], q_m1} and arithmetic-shift right by one.
// Ports:
//   m         - multiplicand (signed, WIDTH)
//   acc       - upper accumulator half (signed, WIDTH)
//   q         - lower half holding the remaining multiplier bits (WIDTH)
//   q_m1      - appended Booth bit q(-1)
//   acc_next  - upper half after the step
//   q_next    - lower half after the step
//   q_m1_next - appended bit after the step
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  // One guard bit keeps acc +/- m exact even for m = -2^(WIDTH-1).
  logic [WIDTH:0] acc_x;
  logic [WIDTH:0] m_x;
  logic [WIDTH:0] sum;

  always_comb begin
    acc_x = {acc[WIDTH-1], acc};
    m_x   = {m[WIDTH-1], m};
    case ({q[0], q_m1})
      2'b01:   sum = acc_x + m_x;
      2'b10:   sum = acc_x - m_x;
      default: sum = acc_x;
    endcase
    // Arithmetic shift of {sum, q, q_m1}: the guard bit is the sign, so the
    // shifted upper half is simply sum[WIDTH:1].
    acc_next  = sum[WIDTH:1];
    q_next    = {sum[0], q[WIDTH-1:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - sequential signed radix-2 Booth multiplier
//
// Purpose: computes ab = a * b (signed) one Booth step per clock. start is a
// level request: every edge with start high reloads operands; iteration runs
// on edges with start low and completes WIDTH edges after start falls.
// Ports:
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset
//   start   - level request to load a/b and begin
//   a       - multiplicand (signed, WIDTH)
//   b       - multiplier (signed, WIDTH)
//   ab      - product of the last completed operation (signed, 2*WIDTH)
//   busy    - high while an operation is loaded or iterating
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] ab,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  booth_state_e state_q, state_d;

  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] q_q;
  logic             q_m1_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] q_next;
  logic             q_m1_next;

  logic             do_step;
  logic             finish;
  logic             busy_d;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .m         (m_q),
    .acc       (acc_q),
    .q         (q_q),
    .q_m1      (q_m1_q),
    .acc_next  (acc_next),
    .q_next    (q_next),
    .q_m1_next (q_m1_next)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and step control. start wins over everything, including an
  // operation in flight (abort and reload).
  always_comb begin
    state_d = state_q;
    do_step = 1'b0;
    finish  = 1'b0;
    if (start) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD, RUN: begin
          do_step = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q    <= '0;
      acc_q  <= '0;
      q_q    <= '0;
      q_m1_q <= 1'b0;
      cnt_q  <= '0;
      ab     <= '0;
      busy   <= 1'b0;
    end else begin
      busy <= busy_d;
      if (start) begin
        m_q    <= a;
        q_q    <= b;
        acc_q  <= '0;
        q_m1_q <= 1'b0;
        cnt_q  <= CNT_W'(WIDTH);
      end else if (do_step) begin
        acc_q  <= acc_next;
        q_q    <= q_next;
        q_m1_q <= q_m1_next;
        cnt_q  <= cnt_q - CNT_W'(1);
        // ab only changes on completion, so an aborted run never shows.
        if (finish) begin
          ab <= {acc_next, q_next};
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - self-checking bench for booth_multiplier
module tb_booth_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] ab;
  logic           busy;

  int vectors = 0;
  int errors  = 0;
  logic signed [2*W-1:0] prev = '0;

  booth_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ab      (ab),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full operation: hold start for 'hold' edges, then drop it and watch
  // WIDTH edges. The reference product is plain signed arithmetic.
  task automatic run_op(input string name, input logic signed [W-1:0] ta,
                        input logic signed [W-1:0] tb_v, input int hold);
    logic signed [2*W-1:0] expv;
    expv = ta * tb_v;
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb_v;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || ab !== prev) begin
        errors++;
        $display("FAIL %s load%0d: busy=%b ab=%h required busy=1 ab=%h", name, i, busy, ab, prev);
      end
    end
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      a = W'($urandom);
      b = W'($urandom);
      vectors++;
      if (k < W) begin
        if (busy !== 1'b1 || ab !== prev) begin
          errors++;
          $display("FAIL %s step%0d: busy=%b ab=%h required busy=1 ab=%h", name, k, busy, ab, prev);
        end
      end else begin
        if (busy !== 1'b0 || ab !== expv) begin
          errors++;
          $display("FAIL %s done (%0d*%0d): busy=%b ab=%h required busy=0 ab=%h", name, ta, tb_v, busy, ab, expv);
        end
      end
    end
    prev = expv;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (ab !== '0) begin
      errors++;
      $display("FAIL reset_ab: ab=%h required 0000", ab);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: busy=%b required 0", busy);
    end
    reset_n = 1'b1;
    prev = '0;
  endtask

  task automatic test_basic();
    run_op("basic_3x17", 8'sd3, 8'sd17, 5);
    // Idle with start low: wiggling a/b must not disturb anything.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = W'($urandom);
      b = W'($urandom);
      vectors++;
      if (busy !== 1'b0 || ab !== 16'sd51) begin
        errors++;
        $display("FAIL idle_hold%0d: busy=%b ab=%h required busy=0 ab=0033", i, busy, ab);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_7x7", 8'sd7, 8'sd7, 5);
  endtask

  task automatic test_corners();
    run_op("corner_m128xm128", -8'sd128, -8'sd128, 1);
    run_op("corner_m128x127", -8'sd128, 8'sd127, 1);
    run_op("corner_m1x1", -8'sd1, 8'sd1, 1);
    run_op("corner_0xm5", 8'sd0, -8'sd5, 2);
    run_op("corner_127xm128", 8'sd127, -8'sd128, 1);
  endtask

  task automatic test_restart();
    @(negedge clk);
    start = 1'b1;
    a = 8'sd5;
    b = 8'sd6;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || ab !== prev || ab === 16'sd30) begin
        errors++;
        $display("FAIL restart_pre%0d: busy=%b ab=%h required busy=1 ab=%h", i, busy, ab, prev);
      end
    end
    run_op("restart_2x3", 8'sd2, 8'sd3, 1);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1;
    a = 8'sd9;
    b = -8'sd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (ab !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b ab=%h required busy=0 ab=0000", busy, ab);
    end
    @(negedge clk);
    reset_n = 1'b1;
    prev = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = W'($urandom);
      b = W'($urandom);
      vectors++;
      if (ab !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset%0d: busy=%b ab=%h required busy=0 ab=0000", i, busy, ab);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1000; n++) begin
      run_op("random", W'($urandom), W'($urandom), int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_corners();
    test_restart();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
